// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared constants and signed saturation-limit helpers for the
//               pipelined multiply-accumulate unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Default operand width, Q-format shift and accumulator guard bits
    localparam int C_WIDTH_DEF = 10;
    localparam int C_FRAC_DEF  = 9;
    localparam int C_ACC_GUARD = 4;

    // Operation mode encoding
    localparam logic C_MODE_MUL = 1'b0;
    localparam logic C_MODE_ACC = 1'b1;

    // Largest value representable in a w-bit two's complement number (w <= 64)
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement number (w <= 64)
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : mac_round_sat
// Description : Combinational round-half-up, arithmetic right shift by FRAC
//               and saturation of a signed value into OUT_W bits. o_clip
//               flags that the result was clamped.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 10,
    parameter int FRAC  = 9
) (
    input  logic signed [IN_W-1:0]  i_v,
    output logic signed [OUT_W-1:0] o_y,
    output logic                    o_clip
);

    localparam logic signed [63:0] C_MAX = sat_max(OUT_W);
    localparam logic signed [63:0] C_MIN = sat_min(OUT_W);

    // One guard bit so the rounding increment can never wrap
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shift;
    logic signed [63:0]   w_shift64;

    assign w_ext = {i_v[IN_W-1], i_v};

    generate
        if (FRAC > 0) begin : g_round
            localparam logic signed [IN_W:0] C_HALF = {{IN_W{1'b0}}, 1'b1} <<< (FRAC - 1);
            assign w_sum = w_ext + C_HALF;
        end else begin : g_no_round
            assign w_sum = w_ext;
        end
    endgenerate

    assign w_shift   = w_sum >>> FRAC;
    assign w_shift64 = 64'(w_shift);

    // Clamp the shifted value to the output range
    always_comb begin
        o_y    = w_shift[OUT_W-1:0];
        o_clip = 1'b0;
        if (w_shift64 > C_MAX) begin
            o_y    = C_MAX[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (w_shift64 < C_MIN) begin
            o_y    = C_MIN[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_pipe
// Description : Three-stage pipelined signed multiply-accumulate with
//               valid/ready handshake, saturating accumulator and rounded,
//               saturated Q-format output. A full output stage with the
//               consumer not ready stalls the entire pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH_DEF,
    parameter int FRAC      = C_FRAC_DEF,
    parameter int ACC_WIDTH = 2 * WIDTH + C_ACC_GUARD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    input  logic                        mode,
    input  logic                        clr_acc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [2*WIDTH-1:0]   prod,
    output logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0]     y,
    output logic                        sat
);

    localparam int C_PW = 2 * WIDTH;
    localparam logic signed [63:0] C_ACC_MAX = sat_max(ACC_WIDTH);
    localparam logic signed [63:0] C_ACC_MIN = sat_min(ACC_WIDTH);

    // Stage 1: registered operands
    logic                    r_s1_valid;
    logic signed [WIDTH-1:0] r_s1_a;
    logic signed [WIDTH-1:0] r_s1_b;
    logic                    r_s1_mode;
    logic                    r_s1_clr;

    // Stage 2: registered product
    logic                    r_s2_valid;
    logic signed [C_PW-1:0]  r_s2_prod;
    logic                    r_s2_mode;
    logic                    r_s2_clr;

    // Stage 3: output registers
    logic                        r_out_valid;
    logic signed [C_PW-1:0]      r_prod;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0]     r_y;
    logic                        r_sat;

    logic                        w_stall;
    logic signed [C_PW-1:0]      w_mult;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH:0]   w_acc_sum;
    logic                        w_acc_ovf;
    logic signed [ACC_WIDTH-1:0] w_acc_sat;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_acc_clip;
    logic signed [ACC_WIDTH-1:0] w_rs_in;
    logic signed [WIDTH-1:0]     w_y;
    logic                        w_y_clip;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Full-precision product; -2^(W-1) squared still fits in 2W signed bits
    assign w_mult = r_s1_a * r_s1_b;

    // Accumulator saturating add, one guard bit to detect overflow
    assign w_prod_ext = ACC_WIDTH'(r_s2_prod);
    assign w_acc_sum  = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_ext[ACC_WIDTH-1], w_prod_ext};
    assign w_acc_ovf  = w_acc_sum[ACC_WIDTH] ^ w_acc_sum[ACC_WIDTH-1];
    assign w_acc_sat  = w_acc_ovf ? (w_acc_sum[ACC_WIDTH] ? C_ACC_MIN[ACC_WIDTH-1:0]
                                                          : C_ACC_MAX[ACC_WIDTH-1:0])
                                  : w_acc_sum[ACC_WIDTH-1:0];

    // Next accumulator value for the sample entering stage 3
    always_comb begin
        w_acc_next = r_acc;
        w_acc_clip = 1'b0;
        if (r_s2_mode == C_MODE_ACC) begin
            if (r_s2_clr) begin
                w_acc_next = w_prod_ext;
            end else begin
                w_acc_next = w_acc_sat;
                w_acc_clip = w_acc_ovf;
            end
        end
    end

    assign w_rs_in = (r_s2_mode == C_MODE_ACC) ? w_acc_next : w_prod_ext;

    mac_round_sat #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .i_v    (w_rs_in),
        .o_y    (w_y),
        .o_clip (w_y_clip)
    );

    // Stage 1: capture the operand pair whenever the pipe advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_clr   <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_mode  <= mode;
            r_s1_clr   <= clr_acc;
        end
    end

    // Stage 2: register the product and carry the control bits along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_clr   <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_mult;
            r_s2_mode  <= r_s1_mode;
            r_s2_clr   <= r_s1_clr;
        end
    end

    // Stage 3: results and accumulator update only for valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_sat       <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_prod <= r_s2_prod;
                r_acc  <= w_acc_next;
                r_y    <= w_y;
                r_sat  <= w_acc_clip | w_y_clip;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign prod      = r_prod;
    assign acc       = r_acc;
    assign y         = r_y;
    assign sat       = r_sat;

endmodule
`default_nettype wire
